// File: rtl/axi_shared_port_arbiter.sv
// Shares one AXI master port between two requesters, one whole transaction at a time.
// Optional round-robin tie-break is compiled in with `define ARB_ROUND_ROBIN_EN (default: m0 wins ties).
module axi_shared_port_arbiter #(
   parameter int DATA_W = 256,
   parameter int STRB_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              axi_clk,
   input  logic              rstn,
   // requester 0 (UART write path)
   input  logic [ADDR_W-1:0] m0_aaddr,
   input  logic [7:0]        m0_alen,
   input  logic [2:0]        m0_asize,
   input  logic [1:0]        m0_aburst,
   input  logic [1:0]        m0_alock,
   input  logic              m0_avalid,
   input  logic              m0_atype,
   output logic              m0_aready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic              m0_wlast,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   // requester 1 (memory checker)
   input  logic [ADDR_W-1:0] m1_aaddr,
   input  logic [7:0]        m1_alen,
   input  logic [2:0]        m1_asize,
   input  logic [1:0]        m1_aburst,
   input  logic [1:0]        m1_alock,
   input  logic              m1_avalid,
   input  logic              m1_atype,
   output logic              m1_aready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic              m1_wlast,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   // shared slave port
   output logic [7:0]        s_aid,
   output logic [ADDR_W-1:0] s_aaddr,
   output logic [7:0]        s_alen,
   output logic [2:0]        s_asize,
   output logic [1:0]        s_aburst,
   output logic [1:0]        s_alock,
   output logic              s_atype,
   output logic              s_avalid,
   input  logic              s_aready,
   output logic [7:0]        s_wid,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   output logic              s_wlast,
   output logic              s_wvalid,
   input  logic              s_wready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [7:0]        s_bid,
   input  logic              s_bvalid,
   output logic              s_bready,
   // status
   output logic              grant,
   output logic              busy,
   output logic              err_wlast
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_WRESP,
      ST_RDATA
   } state_t;

   state_t     state_q, state_d;
   logic       grant_q;
   logic       is_write_q;
   logic [7:0] alen_q;
   logic [8:0] beat_cnt_q;
   logic       err_wlast_q;
   logic       arb_grant;

   // granted requester's view, selected from the registered owner only
   logic              sel_avalid, sel_atype;
   logic              sel_wvalid, sel_wlast;
   logic              sel_rready, sel_bready;
   logic [7:0]        sel_alen;

   // handshake outputs towards whichever requester owns the port
   logic g_aready, g_wready, g_rvalid, g_bvalid;
   logic a_hs, w_beat;

   // the write-response ID is not needed: ownership is tracked locally
   logic unused_bid;
   assign unused_bid = ^s_bid;

   assign sel_avalid = grant_q ? m1_avalid : m0_avalid;
   assign sel_atype  = grant_q ? m1_atype  : m0_atype;
   assign sel_alen   = grant_q ? m1_alen   : m0_alen;
   assign sel_wvalid = grant_q ? m1_wvalid : m0_wvalid;
   assign sel_wlast  = grant_q ? m1_wlast  : m0_wlast;
   assign sel_rready = grant_q ? m1_rready : m0_rready;
   assign sel_bready = grant_q ? m1_bready : m0_bready;

   assign s_aid    = {7'b0, grant_q};
   assign s_wid    = {7'b0, grant_q};
   assign s_aaddr  = grant_q ? m1_aaddr  : m0_aaddr;
   assign s_alen   = sel_alen;
   assign s_asize  = grant_q ? m1_asize  : m0_asize;
   assign s_aburst = grant_q ? m1_aburst : m0_aburst;
   assign s_alock  = grant_q ? m1_alock  : m0_alock;
   assign s_atype  = sel_atype;
   assign s_wdata  = grant_q ? m1_wdata  : m0_wdata;
   assign s_wstrb  = grant_q ? m1_wstrb  : m0_wstrb;
   assign s_wlast  = sel_wlast;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q;
   logic txn_done;

   assign arb_grant = (m0_avalid & m1_avalid) ? ~last_grant_q : m1_avalid;
   assign txn_done  = ((state_q == ST_WRESP) & s_bvalid & sel_bready) |
                      ((state_q == ST_RDATA) & s_rvalid & sel_rready & s_rlast);

   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         last_grant_q <= 1'b1;
      end else if (txn_done) begin
         last_grant_q <= grant_q;
      end
   end
`else
   assign arb_grant = m1_avalid & ~m0_avalid;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      g_aready = 1'b0;
      g_wready = 1'b0;
      g_rvalid = 1'b0;
      g_bvalid = 1'b0;
      s_avalid = 1'b0;
      s_wvalid = 1'b0;
      s_rready = 1'b0;
      s_bready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m0_avalid | m1_avalid) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            s_avalid = sel_avalid;
            g_aready = s_aready;
            if (sel_avalid & s_aready) state_d = sel_atype ? ST_WDATA : ST_RDATA;
         end
         ST_WDATA: begin
            // is_write_q guards the W channel so a read can never open it
            if (is_write_q) begin
               s_wvalid = sel_wvalid;
               g_wready = s_wready;
               if (sel_wvalid & s_wready & sel_wlast) state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            s_bready = sel_bready;
            g_bvalid = s_bvalid;
            if (s_bvalid & sel_bready) state_d = ST_IDLE;
         end
         ST_RDATA: begin
            s_rready = sel_rready;
            g_rvalid = s_rvalid;
            if (s_rvalid & sel_rready & s_rlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign a_hs   = (state_q == ST_ADDR) & s_avalid & s_aready;
   assign w_beat = (state_q == ST_WDATA) & s_wvalid & s_wready;

   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         grant_q     <= 1'b0;
         is_write_q  <= 1'b0;
         alen_q      <= '0;
         beat_cnt_q  <= '0;
         err_wlast_q <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && (m0_avalid || m1_avalid)) begin
            grant_q <= arb_grant;
         end
         if (a_hs) begin
            is_write_q <= sel_atype;
            alen_q     <= sel_alen;
            beat_cnt_q <= '0;
         end
         if (w_beat) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            // early wlast, late wlast, or beats past the burst length all flag the error
            if (sel_wlast && (beat_cnt_q != {1'b0, alen_q})) err_wlast_q <= 1'b1;
            if (!sel_wlast && (beat_cnt_q > {1'b0, alen_q})) err_wlast_q <= 1'b1;
         end
      end
   end

   assign m0_aready = g_aready & ~grant_q;
   assign m1_aready = g_aready &  grant_q;
   assign m0_wready = g_wready & ~grant_q;
   assign m1_wready = g_wready &  grant_q;
   assign m0_rvalid = g_rvalid & ~grant_q;
   assign m1_rvalid = g_rvalid &  grant_q;
   assign m0_bvalid = g_bvalid & ~grant_q;
   assign m1_bvalid = g_bvalid &  grant_q;

   // read payload is broadcast; only rvalid tells a requester the beat is its own
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;
   assign m0_rlast = s_rlast;
   assign m1_rlast = s_rlast;

   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign err_wlast = err_wlast_q;

endmodule

// File: tb/tb_axi_shared_port_arbiter.sv
// Randomised self-checking bench for axi_shared_port_arbiter against a transaction-level model.
// Honours `define ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_axi_shared_port_arbiter;

   localparam int DATA_W = 256;
   localparam int STRB_W = 32;
   localparam int ADDR_W = 32;
   localparam int LIMIT  = 1000;

   logic              axi_clk = 1'b0;
   logic              rstn;
   logic [ADDR_W-1:0] m0_aaddr, m1_aaddr;
   logic [7:0]        m0_alen, m1_alen;
   logic [2:0]        m0_asize, m1_asize;
   logic [1:0]        m0_aburst, m1_aburst, m0_alock, m1_alock;
   logic              m0_avalid, m1_avalid, m0_atype, m1_atype;
   logic              m0_aready, m1_aready;
   logic [DATA_W-1:0] m0_wdata, m1_wdata;
   logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
   logic              m0_wlast, m1_wlast, m0_wvalid, m1_wvalid;
   logic              m0_wready, m1_wready;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [1:0]        m0_rresp, m1_rresp;
   logic              m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
   logic              m0_rready, m1_rready;
   logic              m0_bvalid, m1_bvalid, m0_bready, m1_bready;
   logic [7:0]        s_aid, s_wid, s_alen, s_bid;
   logic [ADDR_W-1:0] s_aaddr;
   logic [2:0]        s_asize;
   logic [1:0]        s_aburst, s_alock, s_rresp;
   logic              s_atype, s_avalid, s_aready;
   logic [DATA_W-1:0] s_wdata, s_rdata;
   logic [STRB_W-1:0] s_wstrb;
   logic              s_wlast, s_wvalid, s_wready;
   logic              s_rlast, s_rvalid, s_rready;
   logic              s_bvalid, s_bready;
   logic              grant, busy, err_wlast;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int last_grant_m = 1;
   bit err_m        = 1'b0;

   always #5 axi_clk = ~axi_clk;

   axi_shared_port_arbiter #(.DATA_W(DATA_W), .STRB_W(STRB_W), .ADDR_W(ADDR_W)) dut (
      .axi_clk(axi_clk), .rstn(rstn),
      .m0_aaddr(m0_aaddr), .m0_alen(m0_alen), .m0_asize(m0_asize), .m0_aburst(m0_aburst),
      .m0_alock(m0_alock), .m0_avalid(m0_avalid), .m0_atype(m0_atype), .m0_aready(m0_aready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
      .m0_wready(m0_wready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m1_aaddr(m1_aaddr), .m1_alen(m1_alen), .m1_asize(m1_asize), .m1_aburst(m1_aburst),
      .m1_alock(m1_alock), .m1_avalid(m1_avalid), .m1_atype(m1_atype), .m1_aready(m1_aready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
      .m1_wready(m1_wready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize), .s_aburst(s_aburst),
      .s_alock(s_alock), .s_atype(s_atype), .s_avalid(s_avalid), .s_aready(s_aready),
      .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_bid(s_bid), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .grant(grant), .busy(busy), .err_wlast(err_wlast)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic bound(input int cyc);
      if (cyc > LIMIT) begin
         check("timeout_cycles", 256'(cyc), 256'(LIMIT));
         finish_test();
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic rbit(input int one_in);
      return 1'($urandom_range(0, one_in - 1) != 0);
   endfunction

   function automatic logic [1:0] onehot(input int w, input logic v);
      return v ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
   endfunction

   // arbitration rule
   function automatic int pick_winner(input bit r0, input bit r1);
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
         return 1 - last_grant_m;
`else
         return 0;
`endif
      end
      return r1 ? 1 : 0;
   endfunction

   task automatic drive_w(input int idx, input logic v, input logic [255:0] d,
                          input logic [31:0] s, input logic l);
      if (idx == 0) begin
         m0_wvalid = v; m0_wdata = d; m0_wstrb = s; m0_wlast = l;
      end else begin
         m1_wvalid = v; m1_wdata = d; m1_wstrb = s; m1_wlast = l;
      end
   endtask

   task automatic quiet_inputs();
      m0_avalid = 0; m1_avalid = 0; m0_wvalid = 0; m1_wvalid = 0; m0_wlast = 0; m1_wlast = 0;
      m0_rready = 0; m1_rready = 0; m0_bready = 0; m1_bready = 0;
      s_aready = 0; s_wready = 0; s_rvalid = 0; s_rlast = 0; s_bvalid = 0;
   endtask

   // One arbitration round; the winner runs a complete transaction unless reset aborts it.
   task automatic run_round(input bit r0, input bit r1, input bit wr0, input bit wr1,
                            input int alen, input int wlast_at, input int aready_hold,
                            input int rst_at_beat);
      int w, cyc, beats;
      bit wr, done, aborted;
      logic [31:0] exp_addr;
      logic [255:0] d;
      logic [31:0] st;
      logic v, rd, l;
      logic [1:0] rsp;

      w  = pick_winner(r0, r1);
      wr = (w == 1) ? wr1 : wr0;
      aborted = 0;

      @(negedge axi_clk);
      m0_aaddr = $urandom; m1_aaddr = $urandom;
      m0_alen = (w == 0) ? 8'(alen) : 8'($urandom_range(0, 255));
      m1_alen = (w == 1) ? 8'(alen) : 8'($urandom_range(0, 255));
      m0_asize = 3'($urandom); m1_asize = 3'($urandom);
      m0_aburst = 2'($urandom); m1_aburst = 2'($urandom);
      m0_alock = 2'($urandom); m1_alock = 2'($urandom);
      m0_atype = wr0; m1_atype = wr1;
      m0_avalid = r0; m1_avalid = r1;
      exp_addr = (w == 1) ? m1_aaddr : m0_aaddr;
      #1;
      check("idle_busy", busy, 0);
      check("idle_s_avalid", s_avalid, 0);
      check("idle_aready", {m1_aready, m0_aready}, 0);

      // address phase; W data offered early must be held off
      cyc = 0; done = 0;
      while (!done) begin
         @(negedge axi_clk);
         s_aready = (cyc >= aready_hold) ? rbit(3) : 1'b0;
         drive_w(w, wr, rand256(), $urandom, 1'b0);
         drive_w(1 - w, rbit(2), rand256(), $urandom, rbit(2));
         #1;
         check("a_grant", grant, 256'(w));
         check("a_busy", busy, 1);
         check("a_s_avalid", s_avalid, 1);
         check("a_s_aaddr", s_aaddr, exp_addr);
         check("a_s_alen", s_alen, 256'(alen));
         check("a_s_atype", s_atype, wr);
         check("a_s_aid", s_aid, 256'(w));
         check("a_aready", {m1_aready, m0_aready}, onehot(w, s_aready));
         check("a_wready_held", {m1_wready, m0_wready}, 0);
         check("a_s_wvalid", s_wvalid, 0);
         done = s_aready;
         cyc++;
         bound(cyc);
      end

      beats = 0; done = 0; cyc = 0;
      if (wr) begin
         while (!done) begin
            @(negedge axi_clk);
            s_aready = 0;
            v = rbit(4); d = rand256(); st = $urandom; l = (beats == wlast_at);
            drive_w(w, v, d, st, l);
            drive_w(1 - w, rbit(2), rand256(), $urandom, rbit(2));
            s_wready = rbit(4);
            #1;
            check("w_s_wvalid", s_wvalid, v);
            check("w_s_wdata", s_wdata, d);
            check("w_s_wstrb", s_wstrb, st);
            check("w_s_wlast", s_wlast, l);
            check("w_s_wid", s_wid, 256'(w));
            check("w_wready", {m1_wready, m0_wready}, onehot(w, s_wready));
            check("w_s_avalid", s_avalid, 0);
            if (v && s_wready) begin
               if (beats == wlast_at) done = 1;
               beats++;
            end
            cyc++;
            bound(cyc);
         end
         // the burst is in error exactly when wlast does not sit on beat alen+1
         if (wlast_at != alen) err_m = 1'b1;
         done = 0; cyc = 0;
         while (!done) begin
            @(negedge axi_clk);
            drive_w(0, 1'b0, '0, '0, 1'b0);
            drive_w(1, 1'b0, '0, '0, 1'b0);
            s_wready = 0;
            s_bvalid = rbit(3);
            s_bid = 8'($urandom);
            rd = rbit(3);
            if (w == 1) begin m1_bready = rd; m0_bready = rbit(2); end
            else begin m0_bready = rd; m1_bready = rbit(2); end
            #1;
            check("b_err_wlast", err_wlast, err_m);
            check("b_bvalid", {m1_bvalid, m0_bvalid}, onehot(w, s_bvalid));
            check("b_s_bready", s_bready, rd);
            check("b_s_wvalid", s_wvalid, 0);
            check("b_busy", busy, 1);
            done = s_bvalid && rd;
            cyc++;
            bound(cyc);
         end
      end else begin
         while (!done) begin
            @(negedge axi_clk);
            s_aready = 0;
            if (rst_at_beat >= 0 && beats == rst_at_beat) begin
               rstn = 0;
               #1;
               check("rst_grant", grant, 0);
               check("rst_busy", busy, 0);
               check("rst_s_rready", s_rready, 0);
               check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
               check("rst_err_wlast", err_wlast, 0);
               last_grant_m = 1;
               err_m = 1'b0;
               aborted = 1;
               quiet_inputs();
               @(negedge axi_clk);
               rstn = 1;
               break;
            end
            s_rvalid = rbit(4); d = rand256(); rsp = 2'($urandom);
            s_rdata = d; s_rresp = rsp; s_rlast = (beats == alen);
            rd = rbit(4);
            if (w == 1) begin m1_rready = rd; m0_rready = rbit(2); end
            else begin m0_rready = rd; m1_rready = rbit(2); end
            drive_w(1 - w, rbit(2), rand256(), $urandom, rbit(2));
            #1;
            check("r_rvalid", {m1_rvalid, m0_rvalid}, onehot(w, s_rvalid));
            check("r_m0_rdata", m0_rdata, d);
            check("r_m1_rdata", m1_rdata, d);
            check("r_rresp", (w == 1) ? m1_rresp : m0_rresp, rsp);
            check("r_rlast", (w == 1) ? m1_rlast : m0_rlast, s_rlast);
            check("r_s_rready", s_rready, rd);
            check("r_wready", {m1_wready, m0_wready}, 0);
            check("r_busy", busy, 1);
            if (s_rvalid && rd) begin
               if (beats == alen) done = 1;
               beats++;
            end
            cyc++;
            bound(cyc);
         end
      end

      if (!aborted) begin
         last_grant_m = w;
         @(negedge axi_clk);
         quiet_inputs();
         #1;
         check("end_busy", busy, 0);
         check("end_err_wlast", err_wlast, err_m);
         check("end_handshakes", {s_avalid, s_wvalid, s_rready, s_bready}, 0);
      end
   endtask

   initial begin
      rstn = 0;
      quiet_inputs();
      m0_aaddr = '0; m1_aaddr = '0; m0_alen = '0; m1_alen = '0;
      m0_asize = '0; m1_asize = '0; m0_aburst = '0; m1_aburst = '0;
      m0_alock = '0; m1_alock = '0; m0_atype = 0; m1_atype = 0;
      m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
      s_rdata = '0; s_rresp = '0; s_bid = '0;
      repeat (3) @(negedge axi_clk);
      #1;
      check("reset_grant", grant, 0);
      check("reset_busy", busy, 0);
      check("reset_err_wlast", err_wlast, 0);
      check("reset_s_aid", s_aid, 0);
      check("reset_s_handshakes", {s_avalid, s_wvalid, s_rready, s_bready}, 0);
      rstn = 1;

      run_round(1, 0, 1, 0, 3, 3, 0, -1);    // m0 write, 4 beats
      run_round(0, 1, 0, 0, 23, 0, 0, -1);   // m1 read, 24 beats
      run_round(1, 1, 1, 0, 2, 2, 0, -1);    // tie, round 1
      run_round(1, 1, 1, 0, 2, 2, 0, -1);    // tie, round 2
      run_round(0, 1, 0, 1, 3, 1, 0, -1);    // m1 write, wlast on beat 2
      run_round(1, 0, 1, 0, 1, 1, 0, -1);    // clean write, error stays sticky
      run_round(1, 0, 0, 0, 7, 0, 0, 4);     // reset during read beat 5
      run_round(1, 1, 1, 1, 2, 2, 10, -1);   // slave stalls address for 10 cycles

      for (int i = 0; i < 40; i++) begin
         bit r0, r1;
         int alen, wl;
         r0 = 1'($urandom_range(0, 1));
         r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
         alen = $urandom_range(0, 7);
         wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, alen + 2) : alen;
         run_round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   alen, wl, $urandom_range(0, 2), -1);
      end

      finish_test();
   end

endmodule

// File: doc/axi_shared_port_arbiter.md
Name: axi_shared_port_arbiter

Overview:
- Shares one AXI master port (combined address channel, `atype` 1=write/0=read, 256-bit data) between two requesters: m0 = UART write path, m1 = memory checker.
- Grants one whole transaction at a time: address, then all data beats, then the write response.
- Sits between the requesters and the DDR controller AXI slave.
- Serialises traffic so bursts never interleave.

Parameters:
- DATA_W, 256, data width of every W/R data port.
- STRB_W, 32, write strobe width (DATA_W/8).
- ADDR_W, 32, address width.

Ports:
- axi_clk  in  1  clock.
- rstn  in  1  async active-low reset.
- mN_aaddr/alen/asize/aburst/alock  in  32/8/3/2/2  requester N address fields (N=0,1).
- mN_avalid, mN_atype  in  1  requester N address valid and type.
- mN_aready  out  1  address accepted.
- mN_wdata/wstrb  in  DATA_W/STRB_W  write data and strobes.
- mN_wlast, mN_wvalid  in  1  write last beat, write valid.
- mN_wready  out  1  write ready.
- mN_rdata  out  DATA_W  read data.
- mN_rresp  out  2  read response.
- mN_rlast, mN_rvalid  out  1  read last beat, read valid.
- mN_rready  in  1  read ready.
- mN_bvalid  out  1  write response valid.
- mN_bready  in  1  write response ready.
- s_aid/s_wid  out  8  {7'b0, grant}.
- s_aaddr/alen/asize/aburst/alock/atype/avalid  out  ..  muxed address channel.
- s_aready  in  1  slave address ready.
- s_wdata/wstrb/wlast/wvalid  out  ..  muxed write data.
- s_wready  in  1  slave write ready.
- s_rdata/rresp/rlast/rvalid  in  ..  slave read channel.
- s_rready  out  1  read ready to slave.
- s_bid  in  8  ignored.
- s_bvalid  in  1  slave write response valid.
- s_bready  out  1  write response ready to slave.
- grant  out  1  current owner.
- busy  out  1  state != IDLE.
- err_wlast  out  1  sticky: wlast beat count differs from alen+1.

Behaviour:
- States: IDLE, ADDR, WDATA, WRESP, RDATA. Registers: state, grant, is_write, alen_q, beat_cnt[8:0].
- IDLE:
  - If any mN_avalid is high, latch the winner into grant and go to ADDR.
  - Arbitration costs 1 cycle; no address is forwarded in IDLE.
  - Both requesting: winner per arbitration policy (Optional Feature).
- ADDR:
  - s_a* = m[grant]_a*, s_avalid = m[grant]_avalid.
  - m[grant]_aready = s_aready; the other requester's aready = 0.
  - On s_avalid & s_aready: latch atype into is_write, latch alen into alen_q, clear beat_cnt.
  - Next state: WDATA if is_write, else RDATA.
- WDATA:
  - W channel passes through for the granted requester only.
  - Each s_wvalid & s_wready beat increments beat_cnt.
  - On the beat with wlast: go to WRESP.
  - Set err_wlast if beat_cnt != alen_q on that beat.
  - Set err_wlast on any beat where beat_cnt > alen_q without wlast.
- WRESP:
  - m[grant]_bvalid = s_bvalid, s_bready = m[grant]_bready.
  - On s_bvalid & s_bready: go to IDLE and record last_grant.
- RDATA:
  - m[grant]_r* = s_r*, s_rready = m[grant]_rready.
  - On s_rvalid & s_rready & s_rlast: go to IDLE and record last_grant.
- Non-granted requester, and every requester in IDLE: aready = wready = rvalid = bvalid = 0. Its rdata is still driven (broadcast).
- Outside the granted phase: s_avalid, s_wvalid, s_rready, s_bready are all 0.
- Muxing is combinational from registered state/grant. Zero added latency per beat after the grant.
- W data presented before the address handshake is held off (wready=0), not buffered.
- Reset (async, any state):
  - state = IDLE, grant = 0, last_grant = 1, beat_cnt = 0, err_wlast = 0, busy = 0.
  - All handshake outputs 0.
- Reset mid-transaction aborts the transaction; the slave must share rstn.
- err_wlast clears only on reset.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid in IDLE, grant = ~last_grant. A single requester always wins.
- Undefined: fixed priority, m0 always wins ties; last_grant is unused.

Test Plan:
- m0 write, alen=3: 4 beats, then bvalid → m0 sees aready, 4 wready, bvalid; s_aid=0; err_wlast=0; busy returns low after B.
- m1 read, alen=23: 24 beats with rlast on beat 24 → m1_rvalid toggles with s_rvalid; m0_rvalid stays 0; state returns to IDLE.
- m0 and m1 both avalid in the same IDLE cycle, two back-to-back rounds:
  - With ARB_ROUND_ROBIN_EN: grants 0 then 1.
  - Without it: grants 0 then 0 while m0 keeps requesting.
- m1 write with wlast on beat 2, alen=3 → err_wlast=1 and sticky; transaction still completes via B.
- rstn pulsed low during RDATA beat 5 → state=IDLE, s_rready=0, grant=0 immediately (asynchronous).
- s_aready held low 10 cycles while m0 write is pending → s_avalid stays 1 and s_aaddr stable; m1 is not granted meanwhile.
